ctrl_pipe_unit: RTL and testbench
=================================

Name: ctrl_pipe_unit

Overview:
Next-generation MIPS control unit for the 5-stage pipeline. It decodes opcode/funct in ID into a control word and registers that word through ID/EX, EX/MEM and MEM/WB. It also detects load-use hazards and inserts bubbles on stall or flush. It adds bne/andi/ori/slti/lui, illegal-opcode trapping and a saturating illegal-opcode counter, all under parameter control.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register-index width
ALUOP_W, 3, ALUOp width (must be ≥3)
EN_EXT_OPS, 1, 1 = decode bne/andi/ori/slti/lui; 0 = these are illegal
CNT_W, 8, illegal-opcode counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (0 = reset)
id_valid  in  1  ID holds a real instruction
id_opcode  in  OP_W  instruction[31:26]
id_rs  in  REG_W  instruction[25:21]
id_rt  in  REG_W  instruction[20:16]
ex_flush  in  1  branch taken or jump resolved in EX; kill ID
hold  in  1  global freeze (memory wait)
stall  out  1  load-use stall; PC and IF/ID must not write
ex_RegDst, ex_ALUOp, ex_ALUSrc, ex_Branch, ex_BranchNe, ex_Jump, ex_sign_or_zero  out  2/ALUOP_W/1/1/1/1/1  ID/EX control
ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg  out  1/1/1/2  ID/EX control
ex_rt  out  REG_W  ID/EX rt, for the hazard compare
mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg  out  1/1/1/2  EX/MEM control
wb_RegWrite, wb_MemtoReg  out  1/2  MEM/WB control
illegal_op  out  1  pulse: an illegal opcode entered ID/EX
illegal_cnt  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Decode (combinational, ID). Fields are RegDst / ALUSrc / MemtoReg / ALUOp / RegWrite / MemRead / MemWrite / Branch / BranchNe / Jump / sign_or_zero:
  - R 000000: 01/0/00/010/1/0/0/0/0/0/1
  - lw 100011: 00/1/01/000/1/1/0/0/0/0/1
  - sw 101011: 00/1/00/000/0/0/1/0/0/0/1
  - beq 000100: 00/0/00/001/0/0/0/1/0/0/1
  - bne 000101: as beq with BranchNe=1
  - j 000010: Jump=1, all else 0, sign_or_zero=1
  - jal 000011: RegDst=10, MemtoReg=10, RegWrite=1, Jump=1
  - addi 001000: 00/1/00/011/1, rest 0, sign_or_zero=1
  - andi 001100: ALUOp=100, ALUSrc=1, RegWrite=1, sign_or_zero=0
  - ori 001101: ALUOp=101, ALUSrc=1, RegWrite=1, sign_or_zero=0
  - slti 001010: ALUOp=110, ALUSrc=1, RegWrite=1, sign_or_zero=1
  - lui 001111: ALUOp=111, ALUSrc=1, RegWrite=1, sign_or_zero=0
- Extended ops: bne, andi, ori, slti and lui decode only when EN_EXT_OPS=1; otherwise they are illegal.
- Illegal opcode: any other opcode decodes to the bubble word with illegal=1. Bubble word = all fields 0, sign_or_zero=1.
- Hazard check, ID side:
  - uses_rt = 1 for R, sw, beq, bne; 0 otherwise.
  - stall = id_valid & ex_MemRead & (ex_rt≠0) & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)) & ~ex_flush.
- ID/EX update, each edge, in priority order:
  - hold=1: all stage registers keep their values.
  - ex_flush or stall or ~id_valid: ID/EX loads the bubble.
  - otherwise: ID/EX loads the decoded word, and ex_rt <= id_rt.
- EX/MEM and MEM/WB shift every edge unless hold=1. EX/MEM takes the ID/EX memory/writeback fields; MEM/WB takes the EX/MEM writeback fields.
- Latency: decoded control appears on ex_* 1 cycle after ID, on mem_* after 2 cycles, on wb_* after 3 cycles.
- illegal_op = 1 for the cycle after an illegal word is loaded into ID/EX. Flushed, stalled or invalid instructions never count. illegal_cnt increments on the same condition and saturates at 2^CNT_W−1.
- Reset (reset=0, asynchronous):
  - All stage registers hold the bubble; ex_rt=0.
  - illegal_op=0, illegal_cnt=0.
  - stall is combinational and therefore reads 0, because ex_MemRead=0.
  - Release is synchronous to the next clk edge. Reset asserted mid-stall clears the stall immediately.
- Simultaneous events:
  - flush+stall: flush wins and stall is 0.
  - hold+flush: hold wins; the flush must be re-presented by its source.
  - Back-to-back lw where the second lw depends on the first: one stall only. After the bubble, ex_MemRead=0.

Test Plan:
- Reset low mid-stream, then released → all ex/mem/wb outputs are bubble, sign_or_zero=1, illegal_cnt=0, stall=0.
- Issue lw, add, j with id_valid=1 and no hazards → ex_* match the decode table 1 cycle later; mem_RegWrite=1 and mem_MemtoReg=01 2 cycles after lw; wb_* 3 cycles after lw.
- lw rt=5 followed by R-type rs=5 → stall=1 for exactly 1 cycle and ID/EX gets a bubble; the R-type enters the cycle after. Repeat with rt=0 → no stall.
- lw rt=5 in EX, beq rt=5 in ID, with ex_flush=1 in the same cycle → stall=0 and ID/EX gets a bubble.
- Opcode 001101 with EN_EXT_OPS=1 → ALUOp=101, sign_or_zero=0. With EN_EXT_OPS=0 → bubble, illegal_op pulses and illegal_cnt becomes 1.
- 300 illegal opcodes with CNT_W=8 → illegal_cnt saturates at 255. hold=1 for 3 cycles freezes every output, and the pipeline resumes unchanged.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// MIPS control unit: ID decode into a control word, carried through ID/EX, EX/MEM and MEM/WB, with load-use stall and illegal-opcode trap.
// Latency: control reaches ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after ID.
// Backpressure: hold freezes every stage; a load-use stall or a flush injects a bubble into ID/EX.
module ctrl_pipe_unit #(
  parameter int OP_W       = 6,
  parameter int REG_W      = 5,
  parameter int ALUOP_W    = 3,
  parameter int EN_EXT_OPS = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_opcode,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               ex_flush,
  input  logic               hold,
  output logic               stall,
  output logic [1:0]         ex_RegDst,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               ex_ALUSrc,
  output logic               ex_Branch,
  output logic               ex_BranchNe,
  output logic               ex_Jump,
  output logic               ex_sign_or_zero,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_RegWrite,
  output logic [1:0]         ex_MemtoReg,
  output logic [REG_W-1:0]   ex_rt,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_RegWrite,
  output logic [1:0]         mem_MemtoReg,
  output logic               wb_RegWrite,
  output logic [1:0]         wb_MemtoReg,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   illegal_cnt
);

  typedef struct packed {
    logic [1:0]         reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               branch;
    logic               branch_ne;
    logic               jump;
    logic               sign_or_zero;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         mem_to_reg;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);

  localparam logic EXT_ON = (EN_EXT_OPS != 0);

  function automatic ctrl_t bubble_word();
    ctrl_t b;
    b              = '0;
    b.sign_or_zero = 1'b1;
    return b;
  endfunction

  ctrl_t            dec_word;
  logic             dec_illegal;
  logic             uses_rt;
  logic             stall_int;
  logic             kill;
  logic             load_dec;

  ctrl_t            idex_q;
  logic [REG_W-1:0] idex_rt_q;
  logic             exmem_mem_read_q;
  logic             exmem_mem_write_q;
  logic             exmem_reg_write_q;
  logic [1:0]       exmem_mem_to_reg_q;
  logic             memwb_reg_write_q;
  logic [1:0]       memwb_mem_to_reg_q;
  logic             illegal_op_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  // Extended ops fall through to the illegal path when they are compiled out.
  always_comb begin
    dec_word    = bubble_word();
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        dec_word.reg_dst   = 2'b01;
        dec_word.alu_op    = ALUOP_W'(3'b010);
        dec_word.reg_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_LW: begin
        dec_word.alu_src    = 1'b1;
        dec_word.mem_to_reg = 2'b01;
        dec_word.reg_write  = 1'b1;
        dec_word.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_word.alu_src   = 1'b1;
        dec_word.mem_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_word.alu_op = ALUOP_W'(3'b001);
        dec_word.branch = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_BNE: begin
        if (EXT_ON) begin
          dec_word.alu_op    = ALUOP_W'(3'b001);
          dec_word.branch    = 1'b1;
          dec_word.branch_ne = 1'b1;
          uses_rt            = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_J: begin
        dec_word.jump = 1'b1;
      end
      OP_JAL: begin
        dec_word.reg_dst    = 2'b10;
        dec_word.mem_to_reg = 2'b10;
        dec_word.reg_write  = 1'b1;
        dec_word.jump       = 1'b1;
      end
      OP_ADDI: begin
        dec_word.alu_op    = ALUOP_W'(3'b011);
        dec_word.alu_src   = 1'b1;
        dec_word.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        if (EXT_ON) begin
          dec_word.alu_src   = 1'b1;
          dec_word.reg_write = 1'b1;
          if (id_opcode == OP_ANDI) begin
            dec_word.alu_op       = ALUOP_W'(3'b100);
            dec_word.sign_or_zero = 1'b0;
          end else if (id_opcode == OP_ORI) begin
            dec_word.alu_op       = ALUOP_W'(3'b101);
            dec_word.sign_or_zero = 1'b0;
          end else if (id_opcode == OP_SLTI) begin
            dec_word.alu_op       = ALUOP_W'(3'b110);
          end else begin
            dec_word.alu_op       = ALUOP_W'(3'b111);
            dec_word.sign_or_zero = 1'b0;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A flush in EX kills the ID instruction anyway, so it must not also stall.
  always_comb begin
    stall_int = id_valid & idex_q.mem_read & (idex_rt_q != '0) &
                ((idex_rt_q == id_rs) | (uses_rt & (idex_rt_q == id_rt))) &
                ~ex_flush;
    kill      = ex_flush | stall_int | ~id_valid;
    load_dec  = ~kill;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q             <= bubble_word();
      idex_rt_q          <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 2'b00;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 2'b00;
      illegal_op_q       <= 1'b0;
      illegal_cnt_q      <= '0;
    end else if (!hold) begin
      if (kill) begin
        idex_q <= bubble_word();
      end else begin
        idex_q    <= dec_word;
        idex_rt_q <= id_rt;
      end
      exmem_mem_read_q   <= idex_q.mem_read;
      exmem_mem_write_q  <= idex_q.mem_write;
      exmem_reg_write_q  <= idex_q.reg_write;
      exmem_mem_to_reg_q <= idex_q.mem_to_reg;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      illegal_op_q       <= load_dec & dec_illegal;
      if (load_dec && dec_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall           = stall_int;
  assign ex_RegDst       = idex_q.reg_dst;
  assign ex_ALUOp        = idex_q.alu_op;
  assign ex_ALUSrc       = idex_q.alu_src;
  assign ex_Branch       = idex_q.branch;
  assign ex_BranchNe     = idex_q.branch_ne;
  assign ex_Jump         = idex_q.jump;
  assign ex_sign_or_zero = idex_q.sign_or_zero;
  assign ex_MemRead      = idex_q.mem_read;
  assign ex_MemWrite     = idex_q.mem_write;
  assign ex_RegWrite     = idex_q.reg_write;
  assign ex_MemtoReg     = idex_q.mem_to_reg;
  assign ex_rt           = idex_rt_q;
  assign mem_MemRead     = exmem_mem_read_q;
  assign mem_MemWrite    = exmem_mem_write_q;
  assign mem_RegWrite    = exmem_reg_write_q;
  assign mem_MemtoReg    = exmem_mem_to_reg_q;
  assign wb_RegWrite     = memwb_reg_write_q;
  assign wb_MemtoReg     = memwb_mem_to_reg_q;
  assign illegal_op      = illegal_op_q;
  assign illegal_cnt     = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: one instance with extended ops enabled, one with them disabled, driven in lockstep.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_flush;
  logic       hold;

  logic       stall_a, ex_alusrc_a, ex_br_a, ex_bne_a, ex_j_a, ex_soz_a, ex_mr_a, ex_mw_a, ex_rw_a;
  logic [1:0] ex_rd_a, ex_m2r_a;
  logic [2:0] ex_alu_a;
  logic [4:0] ex_rt_a;
  logic       mem_mr_a, mem_mw_a, mem_rw_a, wb_rw_a, ill_a;
  logic [1:0] mem_m2r_a, wb_m2r_a;
  logic [7:0] cnt_a;

  logic       stall_b, ex_alusrc_b, ex_br_b, ex_bne_b, ex_j_b, ex_soz_b, ex_mr_b, ex_mw_b, ex_rw_b;
  logic [1:0] ex_rd_b, ex_m2r_b;
  logic [2:0] ex_alu_b;
  logic [4:0] ex_rt_b;
  logic       mem_mr_b, mem_mw_b, mem_rw_b, wb_rw_b, ill_b;
  logic [1:0] mem_m2r_b, wb_m2r_b;
  logic [7:0] cnt_b;

  ctrl_pipe_unit #(.EN_EXT_OPS(1)) u_ext (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_flush(ex_flush), .hold(hold), .stall(stall_a),
    .ex_RegDst(ex_rd_a), .ex_ALUOp(ex_alu_a), .ex_ALUSrc(ex_alusrc_a), .ex_Branch(ex_br_a),
    .ex_BranchNe(ex_bne_a), .ex_Jump(ex_j_a), .ex_sign_or_zero(ex_soz_a), .ex_MemRead(ex_mr_a),
    .ex_MemWrite(ex_mw_a), .ex_RegWrite(ex_rw_a), .ex_MemtoReg(ex_m2r_a), .ex_rt(ex_rt_a),
    .mem_MemRead(mem_mr_a), .mem_MemWrite(mem_mw_a), .mem_RegWrite(mem_rw_a), .mem_MemtoReg(mem_m2r_a),
    .wb_RegWrite(wb_rw_a), .wb_MemtoReg(wb_m2r_a), .illegal_op(ill_a), .illegal_cnt(cnt_a)
  );

  ctrl_pipe_unit #(.EN_EXT_OPS(0)) u_base (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_flush(ex_flush), .hold(hold), .stall(stall_b),
    .ex_RegDst(ex_rd_b), .ex_ALUOp(ex_alu_b), .ex_ALUSrc(ex_alusrc_b), .ex_Branch(ex_br_b),
    .ex_BranchNe(ex_bne_b), .ex_Jump(ex_j_b), .ex_sign_or_zero(ex_soz_b), .ex_MemRead(ex_mr_b),
    .ex_MemWrite(ex_mw_b), .ex_RegWrite(ex_rw_b), .ex_MemtoReg(ex_m2r_b), .ex_rt(ex_rt_b),
    .mem_MemRead(mem_mr_b), .mem_MemWrite(mem_mw_b), .mem_RegWrite(mem_rw_b), .mem_MemtoReg(mem_m2r_b),
    .wb_RegWrite(wb_rw_b), .wb_MemtoReg(wb_m2r_b), .illegal_op(ill_b), .illegal_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_BAD = 6'b111111, OP_BAD2 = 6'b111110;

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        flush;
    logic        hold;
    logic        exp_stall;
    logic [14:0] exp_ex;
    logic [14:0] exp_ex0;
    logic [4:0]  exp_rt;
    logic        ill;
    logic        ill0;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Expected-state model: control word bit order {RegDst,ALUOp,ALUSrc,Branch,BranchNe,Jump,soz,MemRead,MemWrite,RegWrite,MemtoReg}
  logic [14:0] m_ex, m_ex0;
  logic [4:0]  m_mem;
  logic [2:0]  m_wb;
  logic [4:0]  m_rt;
  logic        m_ill, m_ill0;
  int          m_cnt, m_cnt0;

  logic [14:0] W_BUB, W_R, W_LW, W_SW, W_BEQ, W_BNE, W_J, W_JAL, W_ADDI, W_ANDI, W_ORI, W_SLTI, W_LUI;
  vec_t tbl[29];

  function automatic logic [14:0] mk(int rd, int alu, int src, int br, int bne, int jmp, int soz,
                                     int mr, int mw, int rw, int m2r);
    return {rd[1:0], alu[2:0], src[0], br[0], bne[0], jmp[0], soz[0], mr[0], mw[0], rw[0], m2r[1:0]};
  endfunction

  function automatic vec_t mkv(logic valid, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic flush,
                               logic stl, logic [14:0] ex, logic [14:0] ex0, logic [4:0] ert,
                               logic ill, logic ill0);
    vec_t v;
    v.valid = valid; v.op = op; v.rs = rs; v.rt = rt; v.flush = flush; v.hold = 1'b0;
    v.exp_stall = stl; v.exp_ex = ex; v.exp_ex0 = ex0; v.exp_rt = ert; v.ill = ill; v.ill0 = ill0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = W_BUB; m_ex0 = W_BUB; m_mem = W_BUB[4:0]; m_wb = W_BUB[2:0];
    m_rt = '0; m_ill = 1'b0; m_ill0 = 1'b0; m_cnt = 0; m_cnt0 = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " ex"}, 32'({ex_rd_a, ex_alu_a, ex_alusrc_a, ex_br_a, ex_bne_a, ex_j_a, ex_soz_a,
                          ex_mr_a, ex_mw_a, ex_rw_a, ex_m2r_a}), 32'(m_ex));
    chk({tag, " ex_rt"}, 32'(ex_rt_a), 32'(m_rt));
    chk({tag, " mem"}, 32'({mem_mr_a, mem_mw_a, mem_rw_a, mem_m2r_a}), 32'(m_mem));
    chk({tag, " wb"}, 32'({wb_rw_a, wb_m2r_a}), 32'(m_wb));
    chk({tag, " illegal_op"}, 32'(ill_a), 32'(m_ill));
    chk({tag, " illegal_cnt"}, 32'(cnt_a), 32'(m_cnt));
    chk({tag, " base ex"}, 32'({ex_rd_b, ex_alu_b, ex_alusrc_b, ex_br_b, ex_bne_b, ex_j_b, ex_soz_b,
                               ex_mr_b, ex_mw_b, ex_rw_b, ex_m2r_b}), 32'(m_ex0));
    chk({tag, " base illegal_op"}, 32'(ill_b), 32'(m_ill0));
    chk({tag, " base illegal_cnt"}, 32'(cnt_b), 32'(m_cnt0));
  endtask

  // Called #1 after a rising edge: drive, check stall mid-cycle, clock, check registered state.
  task automatic step(input vec_t v, input string tag);
    id_valid = v.valid; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt;
    ex_flush = v.flush; hold = v.hold;
    @(negedge clk);
    chk({tag, " stall"}, 32'(stall_a), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    if (!v.hold) begin
      m_wb = m_mem[2:0];
      m_mem = m_ex[4:0];
      m_ex = v.exp_ex; m_ex0 = v.exp_ex0; m_rt = v.exp_rt;
      m_ill = v.ill; m_ill0 = v.ill0;
      if (v.ill && m_cnt < 255) m_cnt++;
      if (v.ill0 && m_cnt0 < 255) m_cnt0++;
    end
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    W_BUB  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    W_R    = mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    W_LW   = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1);
    W_SW   = mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    W_BEQ  = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    W_BNE  = mk(0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    W_J    = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    W_JAL  = mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2);
    W_ADDI = mk(0, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    W_ANDI = mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    W_ORI  = mk(0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    W_SLTI = mk(0, 6, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    W_LUI  = mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0);

    //              valid op       rs  rt  fl stl ex      ex0     rt  ill ill0
    tbl[0]  = mkv(1, OP_LW,   1,  2,  0, 0, W_LW,   W_LW,   2,  0, 0);
    tbl[1]  = mkv(1, OP_R,    3,  4,  0, 0, W_R,    W_R,    4,  0, 0);
    tbl[2]  = mkv(1, OP_J,    0,  0,  0, 0, W_J,    W_J,    0,  0, 0);
    tbl[3]  = mkv(1, OP_LW,   0,  5,  0, 0, W_LW,   W_LW,   5,  0, 0);
    tbl[4]  = mkv(1, OP_R,    5,  6,  0, 1, W_BUB,  W_BUB,  5,  0, 0);
    tbl[5]  = mkv(1, OP_R,    5,  6,  0, 0, W_R,    W_R,    6,  0, 0);
    tbl[6]  = mkv(1, OP_LW,   1,  0,  0, 0, W_LW,   W_LW,   0,  0, 0);
    tbl[7]  = mkv(1, OP_R,    0,  0,  0, 0, W_R,    W_R,    0,  0, 0);
    tbl[8]  = mkv(1, OP_LW,   1,  5,  0, 0, W_LW,   W_LW,   5,  0, 0);
    tbl[9]  = mkv(1, OP_BEQ,  1,  5,  1, 0, W_BUB,  W_BUB,  5,  0, 0);
    tbl[10] = mkv(1, OP_LW,   2,  7,  0, 0, W_LW,   W_LW,   7,  0, 0);
    tbl[11] = mkv(1, OP_LW,   7,  8,  0, 1, W_BUB,  W_BUB,  7,  0, 0);
    tbl[12] = mkv(1, OP_LW,   7,  8,  0, 0, W_LW,   W_LW,   8,  0, 0);
    tbl[13] = mkv(1, OP_SW,   1,  8,  0, 1, W_BUB,  W_BUB,  8,  0, 0);
    tbl[14] = mkv(1, OP_SW,   1,  8,  0, 0, W_SW,   W_SW,   8,  0, 0);
    tbl[15] = mkv(1, OP_ORI,  0,  9,  0, 0, W_ORI,  W_BUB,  9,  0, 1);
    tbl[16] = mkv(1, OP_ANDI, 0, 10,  0, 0, W_ANDI, W_BUB, 10,  0, 1);
    tbl[17] = mkv(1, OP_SLTI, 0, 11,  0, 0, W_SLTI, W_BUB, 11,  0, 1);
    tbl[18] = mkv(1, OP_LUI,  0, 12,  0, 0, W_LUI,  W_BUB, 12,  0, 1);
    tbl[19] = mkv(1, OP_BNE,  1,  2,  0, 0, W_BNE,  W_BUB,  2,  0, 1);
    tbl[20] = mkv(1, OP_JAL,  0,  0,  0, 0, W_JAL,  W_JAL,  0,  0, 0);
    tbl[21] = mkv(1, OP_ADDI, 3,  4,  0, 0, W_ADDI, W_ADDI, 4,  0, 0);
    tbl[22] = mkv(1, OP_BAD,  0, 11,  0, 0, W_BUB,  W_BUB, 11,  1, 1);
    tbl[23] = mkv(0, OP_LW,   0,  3,  0, 0, W_BUB,  W_BUB, 11,  0, 0);
    tbl[24] = mkv(0, OP_BAD,  0,  3,  0, 0, W_BUB,  W_BUB, 11,  0, 0);
    tbl[25] = mkv(1, OP_BAD,  0,  3,  1, 0, W_BUB,  W_BUB, 11,  0, 0);
    tbl[26] = mkv(1, OP_LW,   0,  3,  0, 0, W_LW,   W_LW,   3,  0, 0);
    tbl[27] = mkv(1, OP_BAD2, 3,  0,  0, 1, W_BUB,  W_BUB,  3,  0, 0);
    tbl[28] = mkv(1, OP_BAD2, 3,  0,  0, 0, W_BUB,  W_BUB,  0,  1, 1);

    // Power-on reset with a live-looking instruction in ID.
    reset = 1'b0; id_valid = 1'b1; id_opcode = OP_LW; id_rs = 5'd1; id_rt = 5'd1;
    ex_flush = 1'b0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset stall", 32'(stall_a), 32'd0);
    reset = 1'b1; id_valid = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted while a load-use stall is active clears it immediately.
    step(mkv(1, OP_LW, 0, 5, 0, 0, W_LW, W_LW, 5, 0, 0), "pre_rst lw");
    id_valid = 1'b1; id_opcode = OP_R; id_rs = 5'd5; id_rt = 5'd6; ex_flush = 1'b0; hold = 1'b0;
    #2;
    chk("mid-stall stall", 32'(stall_a), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("async reset stall", 32'(stall_a), 32'd0);
    check_state("async reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Illegal-opcode counter saturation on both instances.
    for (int k = 0; k < 300; k++)
      step(mkv(1, OP_BAD, 0, 0, 0, 0, W_BUB, W_BUB, 0, 1, 1), $sformatf("sat%0d", k));
    chk("saturated cnt", 32'(cnt_a), 32'd255);
    chk("saturated base cnt", 32'(cnt_b), 32'd255);

    // Hold freezes everything, including a pending illegal_op pulse; a flush under hold is lost.
    step(mkv(1, OP_LW, 0, 1, 0, 0, W_LW, W_LW, 1, 0, 0), "hold lw");
    step(mkv(1, OP_BAD2, 0, 0, 0, 0, W_BUB, W_BUB, 0, 1, 1), "hold bad");
    for (int k = 0; k < 3; k++) begin
      hv = mkv(1, OP_J, 0, 0, 1, 0, W_BUB, W_BUB, 0, 0, 0);
      hv.hold = 1'b1;
      step(hv, $sformatf("hold%0d", k));
    end
    step(mkv(1, OP_R, 2, 3, 0, 0, W_R, W_R, 3, 0, 0), "resume R");
    step(mkv(1, OP_J, 0, 0, 0, 0, W_J, W_J, 0, 0, 0), "resume j");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
